fifo_uart_tx: RTL and testbench

//  Downstream consumer of the 8-bit FIFO: pops bytes via rdreq/rdempty/q and serialises

---
 rtl/fifo_uart_tx.sv | 112 +++++++++++
 tb/tb_fifo_uart_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Pulls bytes from a normal-mode FIFO read port and sends each one as a UART frame on txd.
// The frame is a start bit, 8 data bits LSB first, an optional parity bit and 1-2 stop bits.
module fifo_uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int BAUD_DIV   = CLK_FREQ / BAUD,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdempty,
    input  logic [7:0] q,
    output logic       rdreq,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, REQ, LATCH, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          parity, parity_n;
    logic          txd_n;
    logic          bit_end;

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        parity_n   = parity;
        txd_n      = 1'b1;
        bit_end    = (baud_cnt == BAUD_LAST);

        if (state inside {START, DATA, PARITY, STOP})
            baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;

        case (state)
            IDLE:   if (!rdempty) state_n = REQ;
            REQ:    state_n = LATCH;
            LATCH: begin
                shift_n    = q;
                parity_n   = (^q) ^ (PARITY_ODD != 0);
                baud_cnt_n = '0;
                bit_cnt_n  = '0;
                state_n    = START;
            end
            START:  if (bit_end) state_n = DATA;
            DATA: begin
                if (bit_end) begin
                    shift_n   = {1'b0, shift[7:1]};
                    // bit_cnt wraps 7 -> 0 here, so it arrives at PARITY/STOP already cleared
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: if (bit_end) state_n = STOP;
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_n   = IDLE;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // txd is registered from the next-state view so the line only changes on clock edges
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            PARITY:  txd_n = parity_n;
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        shift  <= shift_n;
        parity <= parity_n;
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            rdreq    <= 1'b0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            rdreq    <= (state_n == REQ);
            txd      <= txd_n;
            busy     <= (state_n != IDLE);
            tx_done  <= (state == STOP) && (state_n == IDLE);
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four parameter variants, each fed by a FIFO model.
// Outputs are compared every cycle against a frame-timeline reference model.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst, rdempty, rdreq, txd, busy, tx_done;
    logic [7:0]    q [NI];

    fifo_uart_tx u0 (.clk(clk), .rst(rst[0]), .rdempty(rdempty[0]), .q(q[0]),
                     .rdreq(rdreq[0]), .txd(txd[0]), .busy(busy[0]), .tx_done(tx_done[0]));
    fifo_uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
                     .clk(clk), .rst(rst[1]), .rdempty(rdempty[1]), .q(q[1]),
                     .rdreq(rdreq[1]), .txd(txd[1]), .busy(busy[1]), .tx_done(tx_done[1]));
    fifo_uart_tx #(.CLK_FREQ(12), .BAUD(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
                     .clk(clk), .rst(rst[2]), .rdempty(rdempty[2]), .q(q[2]),
                     .rdreq(rdreq[2]), .txd(txd[2]), .busy(busy[2]), .tx_done(tx_done[2]));
    fifo_uart_tx #(.STOP_BITS(2)) u3 (
                     .clk(clk), .rst(rst[3]), .rdempty(rdempty[3]), .q(q[3]),
                     .rdreq(rdreq[3]), .txd(txd[3]), .busy(busy[3]), .tx_done(tx_done[3]));

    function automatic int div_of(int i);  return (i == 2) ? 6 : 434; endfunction
    function automatic int pen_of(int i);  return (i == 1 || i == 2) ? 1 : 0; endfunction
    function automatic int podd_of(int i); return (i == 2) ? 1 : 0; endfunction
    function automatic int sb_of(int i);   return (i >= 2) ? 2 : 1; endfunction
    function automatic int flen_of(int i); return (9 + pen_of(i) + sb_of(i)) * div_of(i); endfunction

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] mem [NI][256];
    int   wr [NI];
    int   rd [NI];
    logic pend [NI], rst_req [NI], tog [NI], armed [NI];

    // Reference model: position t within the current frame timeline (REQ, LATCH, bits...)
    bit         act [NI], done_exp [NI];
    int         t [NI];
    logic [7:0] cur [NI];

    // Line-level measurements taken from the DUT pins
    bit          in_frame [NI];
    int          fall [NI], done_cyc [NI], dec_cyc [NI], flen [NI], gap [NI], dgap [NI];
    int          lowrun [NI], n_req [NI], n_done [NI], nrx [NI];
    logic [11:0] samp [NI];
    logic [7:0]  rx [NI][64];
    int          gaps [NI][64];

    task automatic chk(input string nm, input int inst, input logic [31:0] actv, input logic [31:0] expv);
        checks++;
        if (actv !== expv) begin
            errors++;
            if (errors <= 40)
                $display("FAIL u%0d %s cycle=%0d actual=%0h required=%0h", inst, nm, cyc, actv, expv);
        end
    endtask

    // {txd, busy, rdreq, tx_done} the current cycle must show
    function automatic logic [3:0] expect_out(int i);
        int b;
        if (!act[i]) return {1'b1, 1'b0, 1'b0, done_exp[i]};
        if (t[i] == 0) return 4'b1110;
        if (t[i] == 1) return 4'b1100;
        b = (t[i] - 2) / div_of(i);
        if (b == 0) return 4'b0100;
        if (b <= 8) return {cur[i][b-1], 3'b100};
        if (pen_of(i) != 0 && b == 9) return {(^cur[i]) ^ (podd_of(i) != 0), 3'b100};
        return 4'b1100;
    endfunction

    task automatic push(input int i, input logic [7:0] b);
        mem[i][wr[i]] = b;
        wr[i]++;
    endtask

    task automatic step();
        logic [3:0] e;
        int rel, avail;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            e = expect_out(i);
            if (armed[i]) begin
                chk("txd",     i, txd[i],     e[3]);
                chk("busy",    i, busy[i],    e[2]);
                chk("rdreq",   i, rdreq[i],   e[1]);
                chk("tx_done", i, tx_done[i], e[0]);
            end

            if (rdreq[i] === 1'b1) n_req[i]++;
            if (tx_done[i] === 1'b1) begin
                n_done[i]++;
                flen[i] = cyc - fall[i];
                done_cyc[i] = cyc;
                in_frame[i] = 0;
                if (nrx[i] < 64) begin
                    rx[i][nrx[i]] = samp[i][8:1];
                    gaps[i][nrx[i]] = gap[i];
                    nrx[i]++;
                end
            end else if (busy[i] !== 1'b1) begin
                in_frame[i] = 0;
            end
            if (!in_frame[i] && txd[i] === 1'b0) begin
                in_frame[i] = 1;
                fall[i] = cyc;
                gap[i] = cyc - done_cyc[i];
                dgap[i] = cyc - dec_cyc[i];
                samp[i] = '1;
                lowrun[i] = 0;
            end
            if (in_frame[i]) begin
                rel = cyc - fall[i];
                if (txd[i] === 1'b0 && lowrun[i] == rel) lowrun[i]++;
                if (rel % div_of(i) == div_of(i) / 2 && rel / div_of(i) < 12)
                    samp[i][rel / div_of(i)] = txd[i];
            end

            // FIFO read port: data appears the cycle after the request
            if (pend[i]) begin
                if (rd[i] < wr[i]) begin
                    q[i] = mem[i][rd[i]];
                    rd[i]++;
                end else begin
                    chk("pop_on_empty rd", i, rd[i], wr[i] - 1);
                end
            end else begin
                q[i] = 8'($urandom);
            end
            pend[i] = rdreq[i];

            rst[i] = rst_req[i];
            if (rst[i]) armed[i] = 1;
            avail = wr[i] - rd[i] - (pend[i] ? 1 : 0);
            rdempty[i] = (tog[i] && act[i]) ? ((cyc % 2) == 0) : (avail <= 0);

            if (rst[i]) begin
                act[i] = 0;
                done_exp[i] = 0;
            end else if (!act[i]) begin
                done_exp[i] = 0;
                if (!rdempty[i]) begin
                    act[i] = 1;
                    t[i] = 0;
                    cur[i] = mem[i][rd[i]];
                    dec_cyc[i] = cyc;
                end
            end else begin
                t[i]++;
                if (t[i] == 2 + flen_of(i)) begin
                    act[i] = 0;
                    done_exp[i] = 1;
                end
            end
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NI; i++)
            if (act[i] || done_exp[i] || rd[i] != wr[i] || pend[i]) return 0;
        return 1;
    endfunction

    task automatic wait_all(input int budget);
        int n = 0;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        if (!all_idle()) begin
            checks++;
            errors++;
            $display("FAIL wait_idle cycles=%0d limit=%0d", n, budget);
        end
    endtask

    initial begin
        int n, pushed2, saved_done;
        rst = '1;
        rdempty = '1;
        for (int i = 0; i < NI; i++) begin
            q[i] = 8'h00; wr[i] = 0; rd[i] = 0; pend[i] = 0; rst_req[i] = 1; tog[i] = 0;
            armed[i] = 1; act[i] = 0; done_exp[i] = 0; t[i] = 0; cur[i] = 8'h00;
            in_frame[i] = 0; fall[i] = 0; done_cyc[i] = 0; dec_cyc[i] = 0; flen[i] = 0;
            gap[i] = 0; dgap[i] = 0; lowrun[i] = 0; n_req[i] = 0; n_done[i] = 0; nrx[i] = 0;
            samp[i] = '1;
        end
        repeat (3) step();
        chk("reset txd",  0, txd[0],  1);
        chk("reset busy", 0, busy[0], 0);
        chk("reset rdreq", 0, rdreq[0], 0);

        // Single frames on every variant
        for (int i = 0; i < NI; i++) rst_req[i] = 0;
        push(0, 8'h55);
        push(1, 8'h07);
        push(2, 8'h07);
        push(3, 8'h80);
        wait_all(6000);
        chk("frame_len",  0, flen[0], 4340);
        chk("start_low",  0, lowrun[0], 434);
        chk("rx_byte",    0, rx[0][0], 8'h55);
        chk("rdreq_cnt",  0, n_req[0], 1);
        chk("done_cnt",   0, n_done[0], 1);
        chk("req_to_start", 0, dgap[0], 3);
        chk("frame_len",  1, flen[1], 4774);
        chk("parity_bit", 1, samp[1][9], 1);
        chk("rx_byte",    1, rx[1][0], 8'h07);
        chk("frame_len",  2, flen[2], 72);
        chk("parity_bit", 2, samp[2][9], 0);
        chk("frame_len",  3, flen[3], 4774);
        chk("bit7",       3, samp[3][8], 1);
        chk("stop2",      3, samp[3][10], 1);
        chk("rx_byte",    3, rx[3][0], 8'h80);

        // Back-to-back frames on u0; random traffic with a toggling empty flag on u2
        push(0, 8'hA5);
        push(0, 8'h00);
        push(0, 8'hFF);
        tog[2] = 1;
        pushed2 = 0;
        n = 0;
        while (n < 16000 && !(pushed2 == 40 && all_idle())) begin
            step();
            if (pushed2 < 40 && $urandom_range(0, 39) == 0) begin
                push(2, 8'($urandom));
                pushed2++;
            end
            n++;
        end
        if (!all_idle()) begin
            checks++;
            errors++;
            $display("FAIL stress_wait cycles=%0d limit=%0d", n, 16000);
        end
        tog[2] = 0;
        chk("rx_count",  0, nrx[0], 4);
        chk("rx_byte1",  0, rx[0][1], 8'hA5);
        chk("rx_byte2",  0, rx[0][2], 8'h00);
        chk("rx_byte3",  0, rx[0][3], 8'hFF);
        chk("gap2",      0, gaps[0][2], 3);
        chk("gap3",      0, gaps[0][3], 3);
        chk("rdreq_cnt", 0, n_req[0], 4);
        chk("rx_count",  2, nrx[2], 1 + pushed2);
        for (int k = 1; k <= pushed2; k++) chk("rx_stress", 2, rx[2][k], mem[2][k]);

        // Reset in the middle of data bit 4, then a fresh frame once released
        push(0, 8'h3C);
        n = 0;
        while (n < 3000 && !(act[0] && t[0] >= 2 + 5 * 434 + 100)) begin
            step();
            n++;
        end
        chk("reached_bit4", 0, act[0], 1);
        saved_done = n_done[0];
        rst_req[0] = 1;
        push(0, 8'hC3);
        step();
        step();
        chk("rst_txd",   0, txd[0], 1);
        chk("rst_busy",  0, busy[0], 0);
        chk("rst_rdreq", 0, rdreq[0], 0);
        step();
        rst_req[0] = 0;
        wait_all(6000);
        chk("done_after_rst", 0, n_done[0], saved_done + 1);
        chk("rx_after_rst",   0, rx[0][nrx[0] - 1], 8'hC3);
        chk("rst_to_start",   0, dgap[0], 3);
        chk("frame_len2",     0, flen[0], 4340);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
